// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // XOR of the low nbits of data (data frames are at most 9 bits wide).
    function automatic logic calc_parity(input logic [8:0] data, input int unsigned nbits);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_mon_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: deframes rx into a FIFO, flags parity/framing/overflow
// errors and raises a sticky done on idle timeout or a terminator byte.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 1736,
    parameter int         DATA_BITS    = 8,
    parameter int         PARITY       = 0,
    parameter int         STOP_BITS    = 1,
    parameter int         FIFO_DEPTH   = 16,
    parameter int         IDLE_TIMEOUT = 65536,
    parameter int         END_CHAR_EN  = 1,
    parameter logic [7:0] END_CHAR     = 8'h0A
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [31:0]          byte_count,
    output logic                 done
);
    localparam int          CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [31:0] TOUT = 32'(IDLE_TIMEOUT);

    state_t               state, next;
    logic                 rx_meta, rx_s, rx_s_d;
    logic [CW-1:0]        bit_cnt;
    logic                 tick;
    logic [3:0]           nbit;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 shift_en, par_en, stop_ok, stop_bad;
    logic                 push_req;
    logic [DATA_BITS:0]   push_word;
    logic [8:0]           data_ext;
    logic                 fifo_full, fifo_empty, pop, push_ok;
    logic [DATA_BITS:0]   head;
    logic [31:0]          idle_cnt;
    logic                 timeout_hit, end_hit;

    assign tick = (bit_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   if (!rx_s) next = S_START;
            S_START:  if (tick) next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (tick && nbit == 4'(DATA_BITS - 1))
                          next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) next = S_STOP;
            S_STOP:   if (tick) begin
                          if (!rx_s)                           next = S_BREAK;
                          else if (nbit == 4'(STOP_BITS - 1)) next = S_IDLE;
                      end
            S_BREAK:  if (rx_s) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == S_DATA) && tick;
        par_en   = (state == S_PARITY) && tick;
        stop_ok  = (state == S_STOP) && tick && rx_s && (nbit == 4'(STOP_BITS - 1));
        stop_bad = (state == S_STOP) && tick && !rx_s;
    end

    // IDLE keeps the timer primed with a half bit so START samples mid-bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt   <= CW'(CLKS_PER_BIT / 2);
            nbit      <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            push_req  <= 1'b0;
            push_word <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == S_IDLE) bit_cnt <= CW'(CLKS_PER_BIT / 2);
            else if (tick)       bit_cnt <= CW'(CLKS_PER_BIT);
            else                 bit_cnt <= bit_cnt - CW'(1);
            nbit <= (state != next) ? '0 : nbit + {3'b000, tick};
            if (state == S_IDLE) perr <= 1'b0;
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (par_en)
                perr <= calc_parity(9'(shreg), DATA_BITS) ^ rx_s ^ (PARITY == PAR_ODD);
            push_req <= stop_ok;
            if (stop_ok) push_word <= {perr, shreg};
            frame_err <= stop_bad;
        end
    end

    uart_mon_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (push_ok)
    );

    assign pop      = rd_ready && !fifo_empty;
    assign rd_valid = !fifo_empty;
    assign rd_data  = fifo_empty ? '0 : head[DATA_BITS-1:0];
    assign rd_perr  = fifo_empty ? 1'b0 : head[DATA_BITS];

    assign data_ext    = 9'(push_word[DATA_BITS-1:0]);
    assign end_hit     = (END_CHAR_EN != 0) && push_ok && ((data_ext & 9'h0FF) == {1'b0, END_CHAR});
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt == TOUT) && (byte_count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt   <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (rx_s_d && !rx_s)    idle_cnt <= '0;
            else if (idle_cnt < TOUT) idle_cnt <= idle_cnt + 32'd1;
            if (push_ok && byte_count != '1) byte_count <= byte_count + 32'd1;
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            if (timeout_hit || end_hit) done <= 1'b1;
        end
    end

endmodule
